// File: rtl/ms_serial_deserializer_pkg.sv
// ms_deser_pkg: shared types and helpers for the serial deserializer.
//   deser_state_t : FSM state encoding (IDLE, SHIFT)
//   nbits()       : serial frame length for a given data width. When the
//                   PARITY_CHECK_EN macro is defined, one trailing
//                   even-parity bit is included.
package ms_deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    function automatic int nbits(input int width);
`ifdef PARITY_CHECK_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/ms_serial_deserializer_bitcnt.sv
// ms_deser_bitcnt: counts received frame bits.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (takes priority over inc)
//   inc      : count one bit
//   tc       : terminal count, high while count == NBITS-1
// On the terminal count, the counter wraps to 0. It never holds a value
// above NBITS-1.
module ms_deser_bitcnt #(
    parameter int NBITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    localparam int CW = $clog2(NBITS + 1);

    logic [CW-1:0] count;

    assign tc = (count == CW'(NBITS - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc)
            count <= tc ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/ms_serial_deserializer.sv
// ms_serial_deserializer: assembles a WIDTH-bit frame from a strobed serial
// bit stream. The assembled frame is presented on a valid/ready handshake.
//   clk, rst     : clock, synchronous active-high reset
//   din, din_en  : serial bit, and its qualifier
//   frame_start  : arms a new frame; aborts any frame in progress
//   dout         : assembled frame
//   dout_valid   : dout holds an unconsumed frame
//   dout_ready   : the consumer accepts dout
//   overrun      : 1-cycle pulse when a completed frame is dropped
//   busy         : the FSM is in SHIFT
//   parity_err   : even-parity failure of the delivered frame
//                  (present only when PARITY_CHECK_EN is defined)
// Macro PARITY_CHECK_EN appends one even-parity bit to each frame.
module ms_serial_deserializer
    import ms_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             busy
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);
    localparam int NB = nbits(WIDTH);

    deser_state_t     state;
    logic [NB-2:0]    sr;       // previous NB-1 bits; the final bit comes straight from din
    logic [NB-2:0]    sr_next;
    logic [NB-1:0]    full;     // the complete frame, if this bit is the last one
    logic [WIDTH-1:0] data;
    logic             tc;
    logic             shift_en;

    // frame_start has priority: din_en in the same cycle is ignored.
    assign shift_en = (state == SHIFT) && din_en && !frame_start;

    generate
        if (MSB_FIRST) begin : g_msb
            assign full    = {sr, din};
            assign sr_next = full[NB-2:0];
            assign data    = full[NB-1 -: WIDTH];
        end else begin : g_lsb
            assign full    = {din, sr};
            assign sr_next = full[NB-1:1];
            assign data    = full[WIDTH-1:0];
        end
    endgenerate

    ms_deser_bitcnt #(.NBITS(NB)) u_bitcnt (
        .clk (clk),
        .rst (rst),
        .clr (frame_start),
        .inc (shift_en),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (dout_valid && dout_ready)
                dout_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        sr <= sr_next;
                        if (tc) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // A frame consumed in this cycle frees the output register.
                            if (!dout_valid || dout_ready) begin
                                dout       <= data;
                                dout_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                                parity_err <= ^full;
`endif
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ms_serial_deserializer.sv
module tb_ms_serial_deserializer;
    localparam int  W   = 8;
    localparam bit  MSB = 1'b1;
`ifdef PARITY_CHECK_EN
    localparam int  NB  = W + 1;
`else
    localparam int  NB  = W;
`endif

    logic         clk = 1'b0;
    logic         rst, din, din_en, frame_start, dout_ready;
    logic [W-1:0] dout;
    logic         dout_valid, overrun, busy;
`ifdef PARITY_CHECK_EN
    logic         parity_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ms_serial_deserializer #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_en      (din_en),
        .frame_start (frame_start),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overrun     (overrun),
        .busy        (busy)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    // Reference model: the received bits of the current frame sit in a
    // queue. A frame is formed once NB bits have been collected.
    bit           m_busy, m_valid, m_ovr, m_perr;
    logic [W-1:0] m_dout;
    bit           q[$];

    task automatic model_step(input bit r, input bit fs, input bit en, input bit d, input bit rdy);
        bit           fire, done, pe;
        logic [W-1:0] fr;
        if (r) begin
            m_busy = 0; m_valid = 0; m_ovr = 0; m_perr = 0; m_dout = '0; q.delete();
            return;
        end
        m_ovr = 0;
        fire  = m_valid && rdy;
        done  = 0;
        fr    = '0;
        pe    = 0;
        if (fs) begin
            m_busy = 1;
            q.delete();
        end else if (m_busy && en) begin
            q.push_back(d);
            if (q.size() == NB) begin
                done = 1;
                for (int i = 0; i < W; i++)
                    if (MSB) fr[W-1-i] = q[i]; else fr[i] = q[i];
                foreach (q[i]) pe ^= q[i];
                q.delete();
                m_busy = 0;
            end
        end
        if (fire) m_valid = 0;
        if (done) begin
            if (!m_valid) begin
                m_dout = fr; m_valid = 1; m_perr = pe;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare everything.
    task automatic cyc(input bit r, input bit fs, input bit en, input bit d, input bit rdy);
        rst = r; frame_start = fs; din_en = en; din = d; dout_ready = rdy;
        @(posedge clk);
        model_step(r, fs, en, d, rdy);
        #1;
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("dout",       32'(dout),       32'(m_dout));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("busy",       32'(busy),       32'(m_busy));
`ifdef PARITY_CHECK_EN
        chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
    endtask

    function automatic bit frame_bit(input logic [W-1:0] v, input bit par, input int i);
        if (i >= W) return par;
        return MSB ? v[W-1-i] : v[i];
    endfunction

    // Sends frame_start followed by NB bits. Random din_en=0 gaps of up to
    // maxgap cycles are inserted. rdy_last applies on the final bit's cycle.
    task automatic send_frame(input logic [W-1:0] v, input bit par, input int maxgap,
                              input bit rdy, input bit rdy_last);
        cyc(0, 1, 1, 1, rdy);   // din_en in the frame_start cycle must be ignored
        for (int i = 0; i < NB; i++) begin
            int g = (maxgap > 0) ? int'($urandom_range(maxgap, 1)) : 0;
            for (int k = 0; k < g; k++) cyc(0, 0, 0, 1'($urandom), rdy);
            cyc(0, 0, 1, frame_bit(v, par, i), (i == NB - 1) ? rdy_last : rdy);
        end
    endtask

    initial begin
        rst = 1; din = 0; din_en = 0; frame_start = 0; dout_ready = 0;
        cyc(1, 0, 0, 0, 0);
        chk("reset dout_valid", 32'(dout_valid), 0);
        chk("reset busy",       32'(busy),       0);

        // Reset mid-frame, held for 3 cycles.
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 0);
        chk("midreset dout",    32'(dout),       0);
        chk("midreset valid",   32'(dout_valid), 0);
        chk("midreset busy",    32'(busy),       0);
        chk("midreset overrun", 32'(overrun),    0);

        // Clean A5 frame on consecutive strobes.
        send_frame(8'hA5, 1'b0, 0, 0, 0);
        chk("A5 dout",  32'(dout), 32'h00A5);
        chk("A5 valid", 32'(dout_valid), 1);
        chk("model A5", 32'(m_dout), 32'h00A5);
        cyc(0, 0, 0, 0, 1);
        chk("A5 consumed", 32'(dout_valid), 0);

        // Same frame with gaps, then hold it for 5 cycles, then consume.
        send_frame(8'hA5, 1'b0, 3, 0, 0);
        chk("gap A5 dout", 32'(dout), 32'h00A5);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        chk("held dout",  32'(dout), 32'h00A5);
        chk("held valid", 32'(dout_valid), 1);

        // Overrun: 3C completes while A5 is still held.
        send_frame(8'h3C, 1'b0, 1, 0, 0);
        chk("overrun pulse", 32'(overrun), 1);
        chk("overrun dout",  32'(dout), 32'h00A5);
        cyc(0, 0, 0, 0, 0);
        chk("overrun one cycle", 32'(overrun), 0);

        // 3C completes in the same cycle that A5 is consumed.
        send_frame(8'h3C, 1'b0, 1, 0, 1);
        chk("swap dout",    32'(dout), 32'h003C);
        chk("swap valid",   32'(dout_valid), 1);
        chk("swap overrun", 32'(overrun), 0);
        cyc(0, 0, 0, 0, 1);

        // Abort after 5 bits, then a full FF frame.
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
        chk("abort no valid", 32'(dout_valid), 0);
        send_frame(8'hFF, 1'b0, 0, 0, 0);
        chk("abort dout",  32'(dout), 32'h00FF);
        chk("abort valid", 32'(dout_valid), 1);
        cyc(0, 0, 0, 0, 1);

`ifdef PARITY_CHECK_EN
        send_frame(8'hA5, 1'b0, 0, 0, 0);
        chk("par ok err", 32'(parity_err), 0);
        cyc(0, 0, 0, 0, 1);
        send_frame(8'hA5, 1'b1, 0, 0, 0);
        chk("par bad err",  32'(parity_err), 1);
        chk("par bad dout", 32'(dout), 32'h00A5);
        cyc(0, 0, 0, 0, 1);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(199) == 0), ($urandom_range(15) == 0),
                1'($urandom), 1'($urandom), ($urandom_range(2) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
